// File: rtl/sha256_core_mb.sv
// SHA-256 compression engine with a byte-wide register window.
// ROUNDS_PER_CLK rounds are chained combinationally per clock.
// Multi-block chaining: each start picks the IV or the current digest.
// A STATUS write can clear the completed flag or abort a block in flight.
module sha256_core_mb #(
  parameter int unsigned ROUNDS_PER_CLK = 4,
  parameter logic [7:0]  REVISION_DATA  = 8'd60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_w_addr,
  input  logic [7:0] i_data8,
  input  logic       i_we,
  output logic       o_irq,
  output logic [7:0] o_data_mux
);

  if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 ||
        ROUNDS_PER_CLK == 4 || ROUNDS_PER_CLK == 8)) begin : g_bad_rounds
    $error("sha256_core_mb: ROUNDS_PER_CLK must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] ROUND_STEP = 6'(ROUNDS_PER_CLK);
  localparam logic [5:0] LAST_ROUND = 6'(64 - ROUNDS_PER_CLK);

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // SHA-256 primitives
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sum0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] sum1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] sigm0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sigm1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Handshake: a byte write is accepted on any rising edge with i_we=1;
  // there is no back-pressure. Busy-time writes other than abort are dropped.
  state_t           state_q, state_d;
  logic [0:7][31:0] h_q, h_d;      // chaining value H0..H7
  logic [0:7][31:0] v_q, v_d;      // working vars a..h
  logic [511:0]     blk_q, blk_d;  // message block, reused as the W window
  logic [5:0]       round_q, round_d;
  logic             mode_q, mode_d;

  logic             busy;
  logic             status_wr;
  logic             blk_wr;
  logic [0:7][31:0] rnd_v;
  logic [511:0]     sched_w;
  logic [255:0]     digest;
  logic [7:0]       status_byte;
  logic [4:0]       dig_idx;

  assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign status_wr = i_we && (i_w_addr == 7'd65);
  assign blk_wr    = i_we && (i_w_addr < 7'd64);
  assign digest    = h_q;
  assign o_irq     = (state_q == ST_DONE);
  assign status_byte = {2'b00, 1'b0, mode_q, state_q == ST_DONE, busy, state_q == ST_IDLE, 1'b0};
  assign dig_idx   = 5'(i_w_addr - 7'd70);

  // Chained rounds for one clock plus the next window of the W schedule
  always_comb begin : p_rounds
    logic [31:0]      ext [0:15+ROUNDS_PER_CLK];
    logic [0:7][31:0] va;
    logic [31:0]      t1;
    logic [31:0]      t2;
    for (int k = 0; k < 16; k++) ext[k] = blk_q[32*(15-k) +: 32];
    for (int j = 0; j < int'(ROUNDS_PER_CLK); j++)
      ext[16+j] = sigm1(ext[14+j]) + ext[9+j] + sigm0(ext[1+j]) + ext[j];
    va = v_q;
    for (int i = 0; i < int'(ROUNDS_PER_CLK); i++) begin
      t1 = va[7] + sum1(va[4]) + ch(va[4], va[5], va[6]) + K_TAB[round_q + 6'(i)] + ext[i];
      t2 = sum0(va[0]) + maj(va[0], va[1], va[2]);
      va[7] = va[6];
      va[6] = va[5];
      va[5] = va[4];
      va[4] = va[3] + t1;
      va[3] = va[2];
      va[2] = va[1];
      va[1] = va[0];
      va[0] = t1 + t2;
    end
    rnd_v = va;
    sched_w = '0;
    for (int k = 0; k < 16; k++) sched_w[32*(15-k) +: 32] = ext[k+int'(ROUNDS_PER_CLK)];
  end

  // Next-state logic: block writes, start/clear/abort, round progress, final add
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    blk_d   = blk_q;
    round_d = round_q;
    mode_d  = mode_q;
    if (blk_wr && !busy) blk_d[{i_w_addr[5:0], 3'b000} +: 8] = i_data8;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (status_wr) begin
          mode_d = i_data8[4];
          if (i_data8[0]) begin
            state_d = ST_ROUND;
            v_d     = i_data8[4] ? IV : h_q;
            round_d = '0;
          end else if (i_data8[3]) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ROUND: begin
        v_d     = rnd_v;
        blk_d   = sched_w;
        round_d = round_q + ROUND_STEP;
        if (round_q == LAST_ROUND) state_d = ST_FINAL;
        if (status_wr && i_data8[5]) state_d = ST_IDLE;
      end
      ST_FINAL: begin
        if (status_wr && i_data8[5]) begin
          state_d = ST_IDLE;
        end else begin
          for (int i = 0; i < 8; i++) h_d[i] = (mode_q ? IV[i] : h_q[i]) + v_q[i];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= IV;
      v_q     <= '0;
      blk_q   <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      blk_q   <= blk_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  // Combinational register read mux
  always_comb begin
    o_data_mux = 8'h00;
    if (i_w_addr < 7'd64)        o_data_mux = 8'h00;
    else if (i_w_addr == 7'd64)  o_data_mux = 8'h08;
    else if (i_w_addr == 7'd65)  o_data_mux = status_byte;
    else if (i_w_addr == 7'd66)  o_data_mux = REVISION_DATA;
    else if (i_w_addr == 7'd67)  o_data_mux = 8'(ROUNDS_PER_CLK);
    else if (i_w_addr < 7'd70)   o_data_mux = 8'h00;
    else if (i_w_addr < 7'd102)  o_data_mux = digest[{dig_idx, 3'b000} +: 8];
    else                         o_data_mux = 8'hAA;
  end

endmodule

// File: tb/tb_sha256_core_mb.sv
// Bench for sha256_core_mb: three instances (1, 4, 8 rounds per clock)
// share one stimulus stream and are checked against a block-level model.
module tb_sha256_core_mb;

  localparam int RPC [3]     = '{1, 4, 8};
  localparam int EXP_LAT [3] = '{65, 17, 9};

  localparam logic [255:0] IV_VEC  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset / DUTs ----------------
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_w_addr;
  logic [7:0] i_data8;
  logic       i_we;
  logic [2:0] irq;
  logic [7:0] rd [3];

  always #5 i_clk = ~i_clk;

  sha256_core_mb #(.ROUNDS_PER_CLK(1)) u_r1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_w_addr(i_w_addr), .i_data8(i_data8),
    .i_we(i_we), .o_irq(irq[0]), .o_data_mux(rd[0]));
  sha256_core_mb #(.ROUNDS_PER_CLK(4)) u_r4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_w_addr(i_w_addr), .i_data8(i_data8),
    .i_we(i_we), .o_irq(irq[1]), .o_data_mux(rd[1]));
  sha256_core_mb #(.ROUNDS_PER_CLK(8)) u_r8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_w_addr(i_w_addr), .i_data8(i_data8),
    .i_we(i_we), .o_irq(irq[2]), .o_data_mux(rd[2]));

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] exp_q [$];
  logic [7:0]   got [3];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[32*(15-t) +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) hv[i] = hin[32*(7-i) +: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  int           m_cnt  [3];   // cycles left until the digest is ready; 0 = not busy
  bit           m_done [3];
  bit           m_mode [3];
  bit           m_iv   [3];
  logic [255:0] m_h    [3];
  logic [511:0] m_blk  [3];
  logic [511:0] m_snap [3];

  function automatic logic [7:0] model_read(input int i, input logic [6:0] a);
    if (a < 64)        return 8'h00;
    else if (a == 64)  return 8'h08;
    else if (a == 65)  return {3'b000, m_mode[i], m_done[i], m_cnt[i] != 0,
                               (m_cnt[i] == 0) && !m_done[i], 1'b0};
    else if (a == 66)  return 8'd60;
    else if (a == 67)  return 8'(RPC[i]);
    else if (a < 70)   return 8'h00;
    else if (a < 102)  return m_h[i][8*(a-70) +: 8];
    else               return 8'hAA;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_done[i] = 0; m_mode[i] = 0; m_iv[i] = 0;
        m_h[i] = IV_VEC; m_blk[i] = '0; m_snap[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] != 0) begin
          if (i_we && i_w_addr == 7'd65 && i_data8[5]) begin
            m_cnt[i] = 0;
          end else begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              m_h[i] = compress(m_iv[i] ? IV_VEC : m_h[i], m_snap[i]);
              m_done[i] = 1;
            end
          end
        end else if (i_we) begin
          if (i_w_addr < 7'd64) begin
            m_blk[i][8*i_w_addr +: 8] = i_data8;
          end else if (i_w_addr == 7'd65) begin
            m_mode[i] = i_data8[4];
            if (i_data8[0]) begin
              m_snap[i] = m_blk[i];
              m_iv[i]   = i_data8[4];
              m_cnt[i]  = 64 / RPC[i] + 1;
              m_done[i] = 0;
            end else if (i_data8[3]) begin
              m_done[i] = 0;
            end
          end
        end
      end
    end
  end

  // Every-cycle compare of irq and read data against the model
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("irq_r%0d", RPC[i]), 256'(irq[i]), 256'(m_done[i]));
        chk($sformatf("rd_r%0d_a%0d", RPC[i], i_w_addr), 256'(rd[i]), 256'(model_read(i, i_w_addr)));
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    i_we = 1'b1; i_w_addr = a; i_data8 = d;
    @(posedge i_clk); #1;
    i_we = 1'b0;
  endtask

  task automatic write_block(input logic [511:0] b);
    for (int k = 0; k < 64; k++) wr(7'(k), b[8*k +: 8]);
  endtask

  task automatic read_addr(input logic [6:0] a);
    i_w_addr = a;
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) got[i] = rd[i];
    @(posedge i_clk); #1;
  endtask

  task automatic wait_irq(input string nm, input bit chk_lat);
    int  lat [3];
    bit  seen [3];
    int  n;
    bit  all;
    n = 0;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; seen[i] = 0; end
    all = 0;
    while (!all && n < 100) begin
      @(posedge i_clk); #1;
      n++;
      all = 1;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && irq[i]) begin seen[i] = 1; lat[i] = n; end
        if (!seen[i]) all = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!seen[i]) begin
        n_tests++; n_fail++;
        $display("FAIL %s_timeout_r%0d: irq not seen within %0d cycles", nm, RPC[i], n);
      end else if (chk_lat) begin
        chk($sformatf("%s_lat_r%0d", nm, RPC[i]), 256'(lat[i]), 256'(EXP_LAT[i]));
      end
    end
  endtask

  task automatic check_digest(input string nm);
    logic [255:0] lit;
    logic [255:0] dg [3];
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: expected queue empty", nm);
      return;
    end
    lit = exp_q.pop_front();
    for (int k = 0; k < 32; k++) begin
      read_addr(7'(70 + k));
      for (int i = 0; i < 3; i++) dg[i][8*k +: 8] = got[i];
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_model_r%0d", nm, RPC[i]), m_h[i], lit);
      chk($sformatf("%s_dut_r%0d", nm, RPC[i]), dg[i], lit);
    end
  endtask

  task automatic chk_status(input string nm, input logic [7:0] exp);
    read_addr(7'd65);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_status_r%0d", nm, RPC[i]), 256'(got[i]), 256'(exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [6:0] ra [10];
    logic [7:0] rv [10];
    i_rst_n = 1'b0; i_we = 1'b0; i_w_addr = '0; i_data8 = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Reset-state register map
    ra = '{7'd65, 7'd64, 7'd66, 7'd101, 7'd70, 7'd102, 7'd127, 7'd10, 7'd68, 7'd69};
    rv = '{8'h02, 8'h08, 8'h3c, 8'h6a,  8'h19, 8'hAA,  8'hAA,  8'h00, 8'h00, 8'h00};
    for (int j = 0; j < 10; j++) begin
      read_addr(ra[j]);
      for (int i = 0; i < 3; i++)
        chk($sformatf("reset_a%0d_r%0d", ra[j], RPC[i]), 256'(got[i]), 256'(rv[j]));
    end
    read_addr(7'd67);
    for (int i = 0; i < 3; i++) chk($sformatf("rpc_r%0d", RPC[i]), 256'(got[i]), 256'(RPC[i]));
    for (int i = 0; i < 3; i++) chk($sformatf("reset_irq_r%0d", RPC[i]), 256'(irq[i]), 256'(0));

    // "abc" from IV
    exp_q.push_back(D_ABC);
    write_block(B_ABC);
    wr(7'd65, 8'h11);
    wait_irq("abc", 1'b1);
    chk_status("abc_done", 8'h18);
    check_digest("abc");

    // Interrupt clear
    wr(7'd65, 8'h08);
    for (int i = 0; i < 3; i++) chk($sformatf("clear_irq_r%0d", RPC[i]), 256'(irq[i]), 256'(0));
    chk_status("clear", 8'h02);

    // Two-block message, second block chained from H
    exp_q.push_back(D_TWO);
    write_block(B_TWO1);
    wr(7'd65, 8'h11);
    wait_irq("two1", 1'b1);
    write_block(B_TWO2);
    wr(7'd65, 8'h01);
    wait_irq("two2", 1'b1);
    check_digest("two");

    // Empty message, restart straight from DONE
    exp_q.push_back(D_EMPTY);
    write_block(B_EMPTY);
    wr(7'd65, 8'h11);
    wait_irq("empty", 1'b1);
    check_digest("empty");

    // Busy protection: block write and start during ROUND are ignored
    exp_q.push_back(D_ABC);
    write_block(B_ABC);
    wr(7'd65, 8'h11);
    wr(7'd10, 8'hFF);
    wr(7'd65, 8'h11);
    chk_status("busy_run", 8'h14);
    wait_irq("busy", 1'b0);
    check_digest("busy");

    // Abort after three ROUND cycles: H keeps the abc digest
    exp_q.push_back(D_ABC);
    write_block(B_EMPTY);
    wr(7'd65, 8'h01);
    repeat (3) @(posedge i_clk);
    #1;
    wr(7'd65, 8'h20);
    chk_status("abort", 8'h02);
    for (int i = 0; i < 3; i++) chk($sformatf("abort_irq_r%0d", RPC[i]), 256'(irq[i]), 256'(0));
    repeat (70) @(posedge i_clk);
    #1;
    check_digest("abort_h");

    // Fresh "abc" after the abort
    exp_q.push_back(D_ABC);
    write_block(B_ABC);
    wr(7'd65, 8'h11);
    wait_irq("abc2", 1'b1);
    check_digest("abc2");

    // Asynchronous reset in the middle of ROUND
    write_block(B_EMPTY);
    wr(7'd65, 8'h11);
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    i_w_addr = 7'd65;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rst_status_r%0d", RPC[i]), 256'(rd[i]), 256'(8'h02));
    i_w_addr = 7'd101;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rst_h0msb_r%0d", RPC[i]), 256'(rd[i]), 256'(8'h6a));
    for (int i = 0; i < 3; i++) chk($sformatf("rst_irq_r%0d", RPC[i]), 256'(irq[i]), 256'(0));
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk_status("post_rst", 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_core_mb.md
# sha256_core_mb

Parametrised next-generation SHA-256 engine with a byte-wide register interface. It adds a compile-time rounds-per-clock setting, multi-block chaining (start from IV or continue from the current digest), interrupt clear, and abort. It is the compression unit behind the system bus bridge and reuses the team's sum0/sum1/sigm0/sigm1/ch/maj primitives.

## Interface
- ROUNDS_PER_CLK, 4: rounds unrolled per clock; legal values 1, 2, 4, 8. Any other value is a generate-time error.
- REVISION_DATA, 8'd60: value returned at address 66.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_w_addr  in  7  register address, shared by reads and writes.
- i_data8  in  8  write data.
- i_we  in  1  write strobe, one byte per cycle.
- o_irq  out  1  high while the completed flag is set.
- o_data_mux  out  8  combinational read data for i_w_addr.

## Operation
Address map:
- 0-63: message block, write-only; reads return 0.
  - Address k is bits [8k+7:8k] of the 512-bit block.
  - W_t (t=0..15) is bits [32(15-t)+31 : 32(15-t)], so byte 63 is the MSB of W0.
- 64: WHO_AM_I, reads 8'd8.
- 65: STATUS = {2'b0, abort, mode, completed, run, ready, start}.
- 66: REVISION_DATA.
- 67: ROUNDS_PER_CLK.
- 68-69: read 0.
- 70-101: digest {H0..H7}. Address 70+k is bits [8k+7:8k], so H7 LSB is at 70 and H0 MSB is at 101.
- 102-127: read 8'hAA.

STATUS write, while not busy (IDLE or DONE):
- data[0]=1 starts a block.
- data[4] selects the chaining value: 1 means IV (6a09e667 … 5be0cd19); 0 means continue from current H.
- data[3]=1 with data[0]=0 clears completed and returns to IDLE.

STATUS write while busy (ROUND/FINAL):
- data[5]=1 aborts. The engine goes to IDLE, H is unchanged, and the block contents are undefined.
- All other bits are ignored.

Writes to 0-63 while busy are ignored.

FSM:
- IDLE: ready=1. A start write loads the working vars a..h from IV or H (per mode), sets round=0, and moves to ROUND.
- ROUND: R=ROUNDS_PER_CLK chained rounds per cycle.
  - W schedule shifts left R words per cycle.
  - K_t is selected combinationally from round+i.
  - round += R.
  - After 64/R cycles, go to FINAL.
- FINAL (1 cycle): H_i <= H_i + var_i mod 2^32. In IV mode the add uses IV, and H is overwritten.
- DONE: completed=1. A start write or clear write leaves DONE as described above.

Other rules:
- STATUS readback mirrors the current state. start reads 0 after its write cycle. mode holds the last written value. abort reads 0.
- All arithmetic is 32-bit wraparound; no carries are kept.
- A simultaneous i_we to a non-STATUS address in the same cycle has no effect on the FSM.

## Timing
Reset values:
- State IDLE; STATUS = 8'h02; o_irq = 0.
- H = IV.
- Block register is all zeros.
- o_data_mux follows i_w_addr combinationally from reset.

Latency:
- The start write at edge E0 loads a..h.
- ROUND occupies edges E1..E(64/R).
- FINAL updates H at E(64/R+1).
- o_irq rises after E(64/R+1) and stays high through DONE. Per R: R=1 gives 65 cycles, R=4 gives 17, R=8 gives 9.

Interrupt and restart:
- o_irq falls on the edge that takes a clear write or a new start write in DONE.
- A start write in DONE goes directly to ROUND, with no IDLE cycle.

Other timing rules:
- Abort takes effect at the write edge. run=0 and ready=1 on the next cycle. o_irq does not pulse.
- Reset asserted mid-block returns all state to the reset values asynchronously.
- The digest is readable the same cycle o_irq is high; bytes are stable until the next FINAL.

## Test plan
- "abc": write the padded block (W0=61626380, W15=00000018), start with mode=1, R=4. Required: o_irq 17 cycles after the start edge; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block "abcdbcdecdefdefg…nopq" (448 bits): block 1 with mode=1, block 2 with mode=0. Required: final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Empty message at R=1 and at R=8. Required: e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; irq latency 65 and 9 cycles respectively.
- Busy protection: during ROUND, write 0xFF to address 10 and a start write. Required: digest unchanged from the golden value; run stays 1.
- Abort: after 3 ROUND cycles, write STATUS=0x20. Required:
  - next cycle STATUS=0x02 and o_irq stays 0;
  - H still equals its pre-start value;
  - a fresh "abc" run then passes.
- IRQ clear and reset: in DONE, write STATUS=0x08. Required: o_irq=0 and STATUS=0x02. Separately, assert i_rst_n low mid-ROUND. Required: STATUS=0x02 and address 101 reads 0x6a.
